// File: rtl/cpu_commit_pkg.sv
// cpu_commit_pkg
// Shared types and helpers for the commit stage:
//   commit_state_t : LSU handshake state (IDLE / ACCESS)
//   lane_byte()    : picks one byte lane out of a 32-bit data word
package cpu_commit_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } commit_state_t;

   localparam int LANE_W = 8;

   // Returns byte lane 'sel' of 'word'; the caller zero-extends it.
   function automatic logic [LANE_W-1:0] lane_byte(input logic [31:0] word,
                                                   input logic [1:0]  sel);
      logic [LANE_W-1:0] result;
      case (sel)
         2'd0:    result = word[7:0];
         2'd1:    result = word[15:8];
         2'd2:    result = word[23:16];
         default: result = word[31:24];
      endcase
      return result;
   endfunction

endpackage

// File: rtl/cpu_commit_lsu.sv
// cpu_commit_lsu
// Load/store unit of the commit stage: IDLE/ACCESS handshake FSM, ack
// timeout counter, dmem request registers and byte-lane handling.
// Optional feature macro: CPU_COMMIT_BYTE_EN (byte accesses honoured).
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   mem_op, mem_write, byte_op   current instruction is a memory op / store / byte access
//   addr, store_data             effective address, store data
//   stall                        hold upstream (combinational from dmem_ack)
//   retire, retire_load          ack seen this cycle in ACCESS / and it is a load
//   load_value                   load data, lane-selected when byte access
//   exc_misaligned, exc_bus_err  registered one-cycle exception pulses
//   dmem_*                       data memory req/ack interface
module cpu_commit_lsu
   import cpu_commit_pkg::*;
#(
   parameter int REG_WIDTH   = 32,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   mem_op,
   input  logic                   mem_write,
   input  logic                   byte_op,
   input  logic [REG_WIDTH-1:0]   addr,
   input  logic [REG_WIDTH-1:0]   store_data,
   output logic                   stall,
   output logic                   retire,
   output logic                   retire_load,
   output logic [REG_WIDTH-1:0]   load_value,
   output logic                   exc_misaligned,
   output logic                   exc_bus_err,
   output logic                   dmem_req,
   output logic                   dmem_we,
   output logic [REG_WIDTH-1:0]   dmem_addr,
   output logic [REG_WIDTH-1:0]   dmem_wdata,
   output logic [REG_WIDTH/8-1:0] dmem_be,
   input  logic                   dmem_ack,
   input  logic [REG_WIDTH-1:0]   dmem_rdata
);

   localparam int BE_W  = REG_WIDTH / 8;
   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

   commit_state_t        state, next_state;
   logic [CNT_W-1:0]     count;
   logic                 byte_sel, aligned, start, misaligned, ack_hit, timeout;
   logic                 byte_q;
   logic [1:0]           lane_q;

`ifdef CPU_COMMIT_BYTE_EN
   assign byte_sel = byte_op;
`else
   // Byte accesses are not supported in this build: every access is a word.
   logic unused_byte_op;
   assign unused_byte_op = byte_op;
   assign byte_sel       = 1'b0;
`endif

   assign aligned    = byte_sel | (addr[1:0] == 2'b00);
   assign start      = (state == IDLE) & mem_op & aligned;
   assign misaligned = (state == IDLE) & mem_op & ~aligned;
   assign ack_hit    = (state == ACCESS) & dmem_ack;
   // An ack arriving on the timeout cycle wins: the access retires normally.
   assign timeout    = (state == ACCESS) & ~dmem_ack & (count == CNT_W'(ACK_TIMEOUT));

   // ---- state register ----
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // ---- next-state logic ----
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = ACCESS;
         ACCESS:  if (ack_hit | timeout) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // ---- outputs ----
   always_comb begin
      dmem_req    = (state == ACCESS);
      stall       = mem_op & aligned & ~(ack_hit | timeout);
      retire      = ack_hit;
      retire_load = ack_hit & ~dmem_we;
      load_value  = dmem_rdata;
      if (byte_q)
         load_value = {{(REG_WIDTH-LANE_W){1'b0}}, lane_byte(dmem_rdata[31:0], lane_q)};
   end

   // Timeout counter: cleared on entry to ACCESS, saturates at ACK_TIMEOUT.
   always_ff @(posedge clock) begin
      if (reset || start)
         count <= '0;
      else if ((state == ACCESS) && !dmem_ack && (count != CNT_W'(ACK_TIMEOUT)))
         count <= count + 1'b1;
   end

   // Request registers stay frozen from the IDLE->ACCESS edge until the next access.
   always_ff @(posedge clock) begin
      if (reset) begin
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         dmem_be    <= '0;
         byte_q     <= 1'b0;
         lane_q     <= 2'b00;
      end else if (start) begin
         dmem_we    <= mem_write;
         dmem_addr  <= {addr[REG_WIDTH-1:2], 2'b00};
         dmem_wdata <= byte_sel ? {BE_W{store_data[7:0]}} : store_data;
         dmem_be    <= byte_sel ? (BE_W'(1) << addr[1:0]) : '1;
         byte_q     <= byte_sel;
         lane_q     <= addr[1:0];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         exc_misaligned <= 1'b0;
         exc_bus_err    <= 1'b0;
      end else begin
         exc_misaligned <= misaligned;
         exc_bus_err    <= timeout;
      end
   end

endmodule

// File: rtl/cpu_commit_stage.sv
// cpu_commit_stage
// Commit (memory) stage: retires ALU results in one cycle, runs loads and
// stores through cpu_commit_lsu, owns the writeback register and drives
// the commit-side forwarding signals.
// Optional feature macro: CPU_COMMIT_BYTE_EN (byte loads/stores; see LSU).
// Ports:
//   clock, reset        clock, synchronous active-high reset
//   ex_*                commit pipeline register contents
//   stall_o             upstream must hold ex_* stable
//   dmem_*              data memory req/ack interface
//   wb_*                writeback register
//   fw_commit_*         forwarding to the forward unit (loads never forwarded)
//   exc_misaligned, exc_bus_err  one-cycle exception pulses
module cpu_commit_stage
   import cpu_commit_pkg::*;
#(
   parameter int REG_WIDTH   = 32,
   parameter int NUM_REGS    = 32,
   parameter int ACK_TIMEOUT = 255,
   localparam int RD_W       = $clog2(NUM_REGS)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   ex_valid,
   input  logic [RD_W-1:0]        ex_reg_dest,
   input  logic                   ex_reg_write,
   input  logic                   ex_mem_to_reg,
   input  logic                   ex_mem_read,
   input  logic                   ex_mem_write,
   input  logic                   ex_byte,
   input  logic [REG_WIDTH-1:0]   ex_alu_result,
   input  logic [REG_WIDTH-1:0]   ex_rb_data,
   output logic                   stall_o,
   output logic                   dmem_req,
   output logic                   dmem_we,
   output logic [REG_WIDTH-1:0]   dmem_addr,
   output logic [REG_WIDTH-1:0]   dmem_wdata,
   output logic [REG_WIDTH/8-1:0] dmem_be,
   input  logic                   dmem_ack,
   input  logic [REG_WIDTH-1:0]   dmem_rdata,
   output logic                   wb_valid,
   output logic [RD_W-1:0]        wb_reg_dest,
   output logic [REG_WIDTH-1:0]   wb_value,
   output logic                   fw_commit_write,
   output logic [RD_W-1:0]        fw_commit_rd,
   output logic [REG_WIDTH-1:0]   fw_commit_value,
   output logic                   exc_misaligned,
   output logic                   exc_bus_err
);

   logic                 mem_op, retire, retire_load;
   logic [REG_WIDTH-1:0] load_value;

   assign mem_op = ex_valid & (ex_mem_read | ex_mem_write);

   cpu_commit_lsu #(
      .REG_WIDTH   (REG_WIDTH),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) lsu (
      .clock          (clock),
      .reset          (reset),
      .mem_op         (mem_op),
      .mem_write      (ex_mem_write),
      .byte_op        (ex_byte),
      .addr           (ex_alu_result),
      .store_data     (ex_rb_data),
      .stall          (stall_o),
      .retire         (retire),
      .retire_load    (retire_load),
      .load_value     (load_value),
      .exc_misaligned (exc_misaligned),
      .exc_bus_err    (exc_bus_err),
      .dmem_req       (dmem_req),
      .dmem_we        (dmem_we),
      .dmem_addr      (dmem_addr),
      .dmem_wdata     (dmem_wdata),
      .dmem_be        (dmem_be),
      .dmem_ack       (dmem_ack),
      .dmem_rdata     (dmem_rdata)
   );

   // Loads are excluded: their value is not known until the memory answers.
   assign fw_commit_write = ex_valid & ex_reg_write & ~ex_mem_to_reg;
   assign fw_commit_rd    = ex_reg_dest;
   assign fw_commit_value = ex_alu_result;

   // ---- writeback register ----
   always_ff @(posedge clock) begin
      if (reset) begin
         wb_valid    <= 1'b0;
         wb_reg_dest <= '0;
         wb_value    <= '0;
      end else if (retire) begin
         wb_valid    <= ex_reg_write & retire_load;
         wb_reg_dest <= ex_reg_dest;
         wb_value    <= load_value;
      end else if (mem_op) begin
         // Waiting, misaligned or timed out: no writeback this cycle.
         wb_valid    <= 1'b0;
      end else begin
         wb_valid    <= ex_valid & ex_reg_write;
         wb_reg_dest <= ex_reg_dest;
         wb_value    <= ex_alu_result;
      end
   end

endmodule

// File: tb/tb_cpu_commit_stage.sv
module tb_cpu_commit_stage;

   localparam int RW  = 32;
   localparam int NR  = 32;
   localparam int RDW = 5;
   localparam int TO  = 4;

   logic            clock = 1'b0;
   logic            reset;
   logic            ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_byte;
   logic [RDW-1:0]  ex_reg_dest;
   logic [RW-1:0]   ex_alu_result, ex_rb_data;
   logic            stall_o, dmem_req, dmem_we, dmem_ack;
   logic [RW-1:0]   dmem_addr, dmem_wdata, dmem_rdata;
   logic [RW/8-1:0] dmem_be;
   logic            wb_valid, fw_commit_write, exc_misaligned, exc_bus_err;
   logic [RDW-1:0]  wb_reg_dest, fw_commit_rd;
   logic [RW-1:0]   wb_value, fw_commit_value;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [RDW-1:0] rd;
      logic [RW-1:0]  val;
   } wb_t;
   wb_t exp_q[$];

   cpu_commit_stage #(
      .REG_WIDTH   (RW),
      .NUM_REGS    (NR),
      .ACK_TIMEOUT (TO)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .ex_valid        (ex_valid),
      .ex_reg_dest     (ex_reg_dest),
      .ex_reg_write    (ex_reg_write),
      .ex_mem_to_reg   (ex_mem_to_reg),
      .ex_mem_read     (ex_mem_read),
      .ex_mem_write    (ex_mem_write),
      .ex_byte         (ex_byte),
      .ex_alu_result   (ex_alu_result),
      .ex_rb_data      (ex_rb_data),
      .stall_o         (stall_o),
      .dmem_req        (dmem_req),
      .dmem_we         (dmem_we),
      .dmem_addr       (dmem_addr),
      .dmem_wdata      (dmem_wdata),
      .dmem_be         (dmem_be),
      .dmem_ack        (dmem_ack),
      .dmem_rdata      (dmem_rdata),
      .wb_valid        (wb_valid),
      .wb_reg_dest     (wb_reg_dest),
      .wb_value        (wb_value),
      .fw_commit_write (fw_commit_write),
      .fw_commit_rd    (fw_commit_rd),
      .fw_commit_value (fw_commit_value),
      .exc_misaligned  (exc_misaligned),
      .exc_bus_err     (exc_bus_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_ex(input logic v, input logic rw, input logic m2r, input logic rd_op,
                         input logic wr_op, input logic byt, input logic [RDW-1:0] rd,
                         input logic [RW-1:0] alu, input logic [RW-1:0] rb);
      ex_valid      = v;
      ex_reg_write  = rw;
      ex_mem_to_reg = m2r;
      ex_mem_read   = rd_op;
      ex_mem_write  = wr_op;
      ex_byte       = byt;
      ex_reg_dest   = rd;
      ex_alu_result = alu;
      ex_rb_data    = rb;
   endtask

   task automatic clear_ex();
      set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   // Scoreboard: every writeback the DUT produces must match the oldest expectation.
   always @(negedge clock) begin
      if (!reset && wb_valid) begin
         if (exp_q.size() == 0) begin
            check("wb_unexpected", {63'd0, wb_valid}, 64'd0);
         end else begin
            wb_t e;
            e = exp_q.pop_front();
            check("wb_rd", {59'd0, wb_reg_dest}, {59'd0, e.rd});
            check("wb_value", {32'd0, wb_value}, {32'd0, e.val});
         end
      end
   end

   task automatic alu_op(input logic [RDW-1:0] rd, input logic [RW-1:0] val);
      wb_t e;
      set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rd, val, 32'h0);
      e.rd  = rd;
      e.val = val;
      exp_q.push_back(e);
      #1;
      check("alu_stall", {63'd0, stall_o}, 64'd0);
      check("fw_write", {63'd0, fw_commit_write}, 64'd1);
      check("fw_rd", {59'd0, fw_commit_rd}, {59'd0, rd});
      check("fw_value", {32'd0, fw_commit_value}, {32'd0, val});
      tick();
   endtask

   // Aligned access: 'delay' ACCESS cycles without ack, then ack.
   task automatic mem_access(input logic we, input logic [RW-1:0] addr, input logic [RW-1:0] wdata,
                             input logic byt, input logic [RDW-1:0] rd, input logic rw,
                             input int delay, input logic [RW-1:0] rdata,
                             input logic [RW-1:0] exp_addr, input logic [RW-1:0] exp_wdata,
                             input logic [3:0] exp_be, input logic [RW-1:0] exp_wb);
      wb_t e;
      set_ex(1'b1, rw, ~we, ~we, we, byt, rd, addr, wdata);
      #1;
      check("mem_t0_stall", {63'd0, stall_o}, 64'd1);
      check("mem_t0_req", {63'd0, dmem_req}, 64'd0);
      check("mem_fw_write", {63'd0, fw_commit_write}, {63'd0, we & rw});
      for (int i = 0; i < delay; i++) begin
         tick();
         check("mem_wait_req", {63'd0, dmem_req}, 64'd1);
         check("mem_wait_stall", {63'd0, stall_o}, 64'd1);
         check("mem_addr", {32'd0, dmem_addr}, {32'd0, exp_addr});
      end
      tick();
      check("mem_req", {63'd0, dmem_req}, 64'd1);
      check("mem_we", {63'd0, dmem_we}, {63'd0, we});
      check("mem_addr", {32'd0, dmem_addr}, {32'd0, exp_addr});
      check("mem_wdata", {32'd0, dmem_wdata}, {32'd0, exp_wdata});
      check("mem_be", {60'd0, dmem_be}, {60'd0, exp_be});
      dmem_ack   = 1'b1;
      dmem_rdata = rdata;
      if (!we && rw) begin
         e.rd  = rd;
         e.val = exp_wb;
         exp_q.push_back(e);
      end
      #1;
      check("mem_ack_stall", {63'd0, stall_o}, 64'd0);
      tick();
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      clear_ex();
      check("mem_req_drop", {63'd0, dmem_req}, 64'd0);
   endtask

   task automatic misaligned_op(input logic we, input logic [RW-1:0] addr, input logic byt,
                                input logic [RDW-1:0] rd);
      set_ex(1'b1, ~we, ~we, ~we, we, byt, rd, addr, 32'h5555_5555);
      #1;
      check("mis_stall", {63'd0, stall_o}, 64'd0);
      check("mis_req", {63'd0, dmem_req}, 64'd0);
      tick();
      clear_ex();
      check("mis_exc", {63'd0, exc_misaligned}, 64'd1);
      check("mis_req_after", {63'd0, dmem_req}, 64'd0);
      check("mis_wb", {63'd0, wb_valid}, 64'd0);
      tick();
      check("mis_exc_clear", {63'd0, exc_misaligned}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset      = 1'b1;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      clear_ex();
      repeat (3) tick();
      check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
      check("rst_wb_value", {32'd0, wb_value}, 64'd0);
      check("rst_req", {63'd0, dmem_req}, 64'd0);
      check("rst_stall", {63'd0, stall_o}, 64'd0);
      check("rst_be", {60'd0, dmem_be}, 64'd0);
      check("rst_addr", {32'd0, dmem_addr}, 64'd0);
      check("rst_exc", {62'd0, exc_misaligned, exc_bus_err}, 64'd0);
      reset = 1'b0;
      tick();

      // Back-to-back ALU results.
      alu_op(5'd3, 32'd5);
      alu_op(5'd4, 32'd7);
      clear_ex();
      tick();

      // Word load, three wait cycles, then ack; ALU op follows immediately.
      mem_access(1'b0, 32'h100, 32'h0, 1'b0, 5'd5, 1'b1, 3, 32'hDEAD_BEEF,
                 32'h100, 32'h0, 4'hF, 32'hDEAD_BEEF);
      check("load_wb_valid", {63'd0, wb_valid}, 64'd1);
      check("load_wb_value", {32'd0, wb_value}, 64'hDEAD_BEEF);
      alu_op(5'd9, 32'h0000_1234);

      // Word store, ack in the first ACCESS cycle; no writeback.
      mem_access(1'b1, 32'h204, 32'h1122_3344, 1'b0, 5'd7, 1'b0, 0, 32'h0,
                 32'h204, 32'h1122_3344, 4'hF, 32'h0);
      check("store_wb", {63'd0, wb_valid}, 64'd0);

      // Misaligned word store and load.
      misaligned_op(1'b1, 32'h102, 1'b0, 5'd0);
      misaligned_op(1'b0, 32'h301, 1'b0, 5'd8);

      // Ack exactly on the timeout cycle: normal retire.
      mem_access(1'b0, 32'h400, 32'h0, 1'b0, 5'd10, 1'b1, TO, 32'hCAFE_F00D,
                 32'h400, 32'h0, 4'hF, 32'hCAFE_F00D);

      // Store that is never acknowledged: bus error after the timeout.
      set_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h300, 32'h9999_0000);
      for (int i = 0; i < TO; i++) begin
         tick();
         check("to_wait_stall", {63'd0, stall_o}, 64'd1);
         check("to_wait_req", {63'd0, dmem_req}, 64'd1);
      end
      tick();
      check("to_last_req", {63'd0, dmem_req}, 64'd1);
      check("to_last_stall", {63'd0, stall_o}, 64'd0);
      check("to_no_exc_yet", {63'd0, exc_bus_err}, 64'd0);
      tick();
      clear_ex();
      check("to_bus_err", {63'd0, exc_bus_err}, 64'd1);
      check("to_req_drop", {63'd0, dmem_req}, 64'd0);
      tick();
      check("to_bus_err_clear", {63'd0, exc_bus_err}, 64'd0);

      // Timed-out load is dropped (scoreboard flags any writeback).
      set_ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd12, 32'h500, 32'h0);
      repeat (TO + 2) tick();
      clear_ex();
      check("to_load_exc", {63'd0, exc_bus_err}, 64'd1);
      check("to_load_wb", {63'd0, wb_valid}, 64'd0);

`ifdef CPU_COMMIT_BYTE_EN
      mem_access(1'b1, 32'h203, 32'h0000_00AB, 1'b1, 5'd0, 1'b0, 1, 32'h0,
                 32'h200, 32'hABAB_ABAB, 4'b1000, 32'h0);
      mem_access(1'b0, 32'h201, 32'h0, 1'b1, 5'd13, 1'b1, 1, 32'h1234_5678,
                 32'h200, 32'h0, 4'b0010, 32'h0000_0056);
`else
      // Without byte support a byte request at an odd address is a misaligned word.
      misaligned_op(1'b1, 32'h203, 1'b1, 5'd0);
`endif

      // Reset during ACCESS, then a late ack.
      set_ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 32'h600, 32'h0);
      tick();
      tick();
      check("rst_acc_req", {63'd0, dmem_req}, 64'd1);
      reset = 1'b1;
      clear_ex();
      tick();
      check("rst_acc_req_drop", {63'd0, dmem_req}, 64'd0);
      reset      = 1'b0;
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h7777_7777;
      tick();
      dmem_ack   = 1'b0;
      check("late_ack_wb", {63'd0, wb_valid}, 64'd0);
      check("late_ack_exc", {62'd0, exc_misaligned, exc_bus_err}, 64'd0);
      check("late_ack_req", {63'd0, dmem_req}, 64'd0);

      alu_op(5'd1, 32'hFFFF_FFFF);
      clear_ex();
      repeat (3) tick();
      check("sb_drain", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cpu_commit_stage.md
# cpu_commit_stage

Commit (memory) stage of the custom CPU pipeline, sitting between the execute-stage output register and writeback. It retires ALU results in one cycle and runs load/store transactions against the data memory through a req/ack handshake, stalling upstream while a transaction is outstanding. It also drives the commit-side forwarding signals consumed by the forward unit.

## Interface
- REG_WIDTH, 32, data/address width
- NUM_REGS, 32, register count; RD_W = $clog2(NUM_REGS)
- ACK_TIMEOUT, 255, max cycles in ACCESS before abort
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- ex_valid  in  1  commit pipeline register holds an instruction
- ex_reg_dest  in  RD_W  destination register
- ex_reg_write / ex_mem_to_reg / ex_mem_read / ex_mem_write  in  1 each  control bits
- ex_byte  in  1  byte access (honoured only with macro)
- ex_alu_result  in  REG_WIDTH  ALU result / memory address
- ex_rb_data  in  REG_WIDTH  store data
- stall_o  out  1  upstream must hold ex_* stable
- dmem_req / dmem_we  out  1  request, write enable
- dmem_addr / dmem_wdata  out  REG_WIDTH  word address (low 2 bits zero), write data
- dmem_be  out  REG_WIDTH/8  byte enables
- dmem_ack  in  1  transaction complete; dmem_rdata  in  REG_WIDTH  read data valid with ack
- wb_valid / wb_reg_dest / wb_value  out  1 / RD_W / REG_WIDTH  writeback register
- fw_commit_write / fw_commit_rd / fw_commit_value  out  1 / RD_W / REG_WIDTH  forwarding
- exc_misaligned / exc_bus_err  out  1  one-cycle exception pulses

## Operation
- mem op = ex_valid & (ex_mem_read | ex_mem_write). Aligned = ex_alu_result[1:0]==0 (byte ops always aligned with macro).
- FSM IDLE/ACCESS. IDLE + aligned mem op: latch addr/wdata/be/we/load flags, go ACCESS. ACCESS: dmem_req=1; on dmem_ack go IDLE; on counter==ACK_TIMEOUT go IDLE, pulse exc_bus_err, drop instruction (no writeback).
- stall_o = mem op & aligned & !(state==ACCESS & (dmem_ack | timeout)); combinational from dmem_ack.
- Non-memory instr (no stall): at edge wb_valid<=ex_valid&ex_reg_write, wb_value<=ex_alu_result.
- Load retire at ack edge: wb_valid<=ex_reg_write, wb_value<=dmem_rdata (byte-selected per macro). Store retire: wb_valid<=0.
- Misaligned word mem op in IDLE: no request, no stall, exc_misaligned pulses next cycle, wb_valid<=0.
- Forwarding combinational: fw_commit_write = ex_valid & ex_reg_write & !ex_mem_to_reg; rd/value = ex_reg_dest/ex_alu_result. Loads never forwarded (hazard unit stalls).
- dmem_ack while IDLE ignored.

## Timing
- Reset values: all outputs 0, state IDLE, timeout counter 0. Reset mid-ACCESS: dmem_req low the cycle after reset edge; late ack ignored.
- ALU latency 1 cycle, back-to-back, no bubbles.
- Load/store: T0 IDLE stall; T1 dmem_req=1; ack at Tn -> wb_valid at Tn+1, next ex instruction accepted at Tn edge. Minimum 2 cycles per memory op.
- dmem_* stable while dmem_req high; req drops the cycle after ack.
- Timeout counter clears on entering ACCESS, increments each ACCESS cycle without ack; ack on the timeout cycle wins (normal retire).

## Configuration
- CPU_COMMIT_BYTE_EN defined: ex_byte honoured; byte store replicates rb_data[7:0] to all lanes, dmem_be one-hot at addr[1:0]; byte load zero-extends selected lane.
- Undefined: ex_byte ignored, all accesses word, dmem_be all ones, wb_value = dmem_rdata.

## Structure
- Shared package: commit state enum, byte-lane select/extend function.
- One sub-module: cpu_commit_lsu (FSM, timeout counter, dmem handshake, lane logic); top handles forwarding and writeback register.

## Test plan
- ALU stream r3=5, r4=7, back-to-back -> wb_valid two consecutive cycles, values 5,7, stall_o never high.
- Word load addr 0x100, ack after 3 ACCESS cycles, rdata 0xDEADBEEF -> stall 4 cycles, wb_value 0xDEADBEEF one cycle after ack.
- Word store addr 0x102 -> no dmem_req, exc_misaligned pulse, wb_valid 0.
- Store with ack never asserted, ACK_TIMEOUT=4 -> exc_bus_err after 4 ACCESS cycles, req drops, stall releases.
- Macro on: byte store 0xAB to 0x203 -> dmem_be 4'b1000, wdata 0xABABABAB; byte load rdata 0x12345678 addr 0x201 -> wb 0x56.
- Reset asserted during ACCESS then ack -> req 0 after reset, no wb_valid, no exception.
